// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: registers fetched words into decode packets, applying stalls and flushes.
// Define IFID_IMM_FUSE_EN to fuse flagged opcode words with the immediate word that follows them.
module if_id_buffer #(
  parameter int WORD_W       = 16,
  parameter int PC_W         = 32,
  parameter int IMM_FLAG_BIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_hold,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_imm,
  output logic              out_has_imm,
  output logic [PC_W-1:0]   out_pc
);

  logic              out_valid_next;
  logic [WORD_W-1:0] out_instr_next;
  logic [WORD_W-1:0] out_imm_next;
  logic              out_has_imm_next;
  logic [PC_W-1:0]   out_pc_next;

  // A flush overrides a stall, so fetch must be released to load the new target.
  assign fetch_hold = stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_imm     <= '0;
      out_has_imm <= 1'b0;
      out_pc      <= '0;
    end else begin
      out_valid   <= out_valid_next;
      out_instr   <= out_instr_next;
      out_imm     <= out_imm_next;
      out_has_imm <= out_has_imm_next;
      out_pc      <= out_pc_next;
    end
  end

`ifdef IFID_IMM_FUSE_EN
  typedef enum logic {
    EXPECT_OP = 1'b0,
    WAIT_IMM  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] pend_word;
  logic [WORD_W-1:0] pend_word_next;
  logic [PC_W-1:0]   pend_pc;
  logic [PC_W-1:0]   pend_pc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EXPECT_OP;
      pend_word <= '0;
      pend_pc   <= '0;
    end else begin
      state     <= state_next;
      pend_word <= pend_word_next;
      pend_pc   <= pend_pc_next;
    end
  end

  always_comb begin
    state_next       = state;
    pend_word_next   = pend_word;
    pend_pc_next     = pend_pc;
    out_valid_next   = out_valid;
    out_instr_next   = out_instr;
    out_imm_next     = out_imm;
    out_has_imm_next = out_has_imm;
    out_pc_next      = out_pc;

    if (flush) begin
      // Drop any half-assembled instruction; out_pc keeps the last packet address.
      state_next       = EXPECT_OP;
      pend_word_next   = '0;
      pend_pc_next     = '0;
      out_valid_next   = 1'b0;
      out_instr_next   = '0;
      out_imm_next     = '0;
      out_has_imm_next = 1'b0;
    end else if (!stall) begin
      out_valid_next   = 1'b0;
      out_instr_next   = '0;
      out_imm_next     = '0;
      out_has_imm_next = 1'b0;
      case (state)
        EXPECT_OP: begin
          if (in_valid) begin
            if (in_word[IMM_FLAG_BIT]) begin
              pend_word_next = in_word;
              pend_pc_next   = in_pc;
              state_next     = WAIT_IMM;
            end else begin
              out_valid_next = 1'b1;
              out_instr_next = in_word;
              out_pc_next    = in_pc;
            end
          end
        end
        WAIT_IMM: begin
          // The immediate is taken verbatim, even if its flag bit happens to be set.
          if (in_valid) begin
            out_valid_next   = 1'b1;
            out_instr_next   = pend_word;
            out_imm_next     = in_word;
            out_has_imm_next = 1'b1;
            out_pc_next      = pend_pc;
            state_next       = EXPECT_OP;
          end
        end
        default: state_next = EXPECT_OP;
      endcase
    end
  end
`else
  always_comb begin
    out_valid_next   = out_valid;
    out_instr_next   = out_instr;
    out_imm_next     = '0;
    out_has_imm_next = 1'b0;
    out_pc_next      = out_pc;

    if (flush) begin
      out_valid_next = 1'b0;
      out_instr_next = '0;
    end else if (!stall) begin
      out_valid_next = in_valid;
      out_instr_next = in_valid ? in_word : '0;
      if (in_valid) begin
        out_pc_next = in_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed scenarios followed by random stimulus,
// checked every cycle against a queue-based reference model.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;
  logic        fetch_hold;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_has_imm;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  if_id_buffer #(
    .WORD_W(16),
    .PC_W(32),
    .IMM_FLAG_BIT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_word(in_word),
    .in_pc(in_pc),
    .stall(stall),
    .flush(flush),
    .fetch_hold(fetch_hold),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_imm(out_imm),
    .out_has_imm(out_has_imm),
    .out_pc(out_pc)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has_imm;
    logic [31:0] pc;
    logic        hold;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: the visible packet plus a queue holding at most one unpaired opcode.
  obs_t        m_out = '0;
  logic [15:0] pend_word_q[$];
  logic [31:0] pend_pc_q[$];

  task automatic model_step(input logic r, input logic v, input logic [15:0] w,
                            input logic [31:0] pc, input logic st, input logic fl);
    if (r) begin
      m_out = '0;
      pend_word_q.delete();
      pend_pc_q.delete();
    end else if (fl) begin
      m_out.valid   = 1'b0;
      m_out.instr   = '0;
      m_out.imm     = '0;
      m_out.has_imm = 1'b0;
      pend_word_q.delete();
      pend_pc_q.delete();
    end else if (!st) begin
      m_out.valid   = 1'b0;
      m_out.instr   = '0;
      m_out.imm     = '0;
      m_out.has_imm = 1'b0;
      if (v) begin
        if (pend_word_q.size() > 0) begin
          m_out.valid   = 1'b1;
          m_out.instr   = pend_word_q.pop_front();
          m_out.pc      = pend_pc_q.pop_front();
          m_out.imm     = w;
          m_out.has_imm = 1'b1;
`ifdef IFID_IMM_FUSE_EN
        end else if (w[15]) begin
          pend_word_q.push_back(w);
          pend_pc_q.push_back(pc);
`endif
        end else begin
          m_out.valid = 1'b1;
          m_out.instr = w;
          m_out.pc    = pc;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] w,
                       input logic [31:0] pc, input logic st, input logic fl);
    obs_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_word  = w;
    in_pc    = pc;
    stall    = st;
    flush    = fl;
    model_step(r, v, w, pc, st, fl);
    e      = m_out;
    e.hold = st & ~fl;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per clock, one line per failing transaction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{valid: out_valid, instr: out_instr, imm: out_imm, has_imm: out_has_imm,
              pc: out_pc, hold: fetch_hold};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL packet_check t=%0t: got v=%b instr=%h imm=%h has_imm=%b pc=%h hold=%b, expected v=%b instr=%h imm=%h has_imm=%b pc=%h hold=%b",
                   $time, a.valid, a.instr, a.imm, a.has_imm, a.pc, a.hold,
                   e.valid, e.instr, e.imm, e.has_imm, e.pc, e.hold);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_cnt;
    logic [15:0] w;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_word  = 16'h1234;
    in_pc    = 32'h10;
    stall    = 1'b0;
    flush    = 1'b0;

    // Reset held two cycles with a word presented.
    drive(1, 1, 16'h1234, 32'h10, 0, 0);
    drive(1, 1, 16'h1234, 32'h10, 0, 0);
    // Single-word stream.
    drive(0, 1, 16'h0101, 32'h20, 0, 0);
    drive(0, 1, 16'h0202, 32'h21, 0, 0);
    // Two-word instruction then idle.
    drive(0, 1, 16'h8005, 32'h30, 0, 0);
    drive(0, 1, 16'hBEEF, 32'h31, 0, 0);
    drive(0, 0, 16'h0000, 32'h32, 0, 0);
    // Three-cycle stall while holding packet 0101.
    drive(0, 1, 16'h0101, 32'h40, 0, 0);
    drive(0, 1, 16'h0202, 32'h41, 1, 0);
    drive(0, 1, 16'h0202, 32'h41, 1, 0);
    drive(0, 1, 16'h0202, 32'h41, 1, 0);
    drive(0, 1, 16'h0202, 32'h41, 0, 0);
    // Flush while an opcode waits for its immediate.
    drive(0, 1, 16'h8005, 32'h48, 0, 0);
    drive(0, 1, 16'h1111, 32'h49, 0, 1);
    drive(0, 1, 16'h0303, 32'h50, 0, 0);
    // Flush and stall together, then an immediate whose flag bit is set.
    drive(0, 1, 16'h8007, 32'h60, 0, 0);
    drive(0, 1, 16'h0404, 32'h61, 1, 1);
    drive(0, 1, 16'h8009, 32'h70, 0, 0);
    drive(0, 0, 16'h0000, 32'h71, 0, 0);
    drive(0, 1, 16'h8123, 32'h71, 0, 0);
    // Reset in the middle of assembly.
    drive(0, 1, 16'h800A, 32'h80, 0, 0);
    drive(1, 1, 16'h5555, 32'h81, 0, 0);
    drive(0, 1, 16'h0606, 32'h90, 0, 0);

    pc_cnt = 32'h100;
    for (int i = 0; i < 800; i++) begin
      w = 16'($urandom);
      w[15] = ($urandom_range(0, 99) < 35);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75), w, pc_cnt,
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 6));
      if (in_valid && !stall) pc_cnt = pc_cnt + 32'd1;
    end

    drive(0, 0, 16'h0000, pc_cnt, 0, 0);
    drive(0, 0, 16'h0000, pc_cnt, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_check: %0d expected packets left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

IF/ID pipeline register and instruction assembler between the fetch stage and decode. Captures the 16-bit words streamed by fetch each cycle and fuses two-word instructions (opcode word + 16-bit immediate word) into one decode packet. Applies hazard-unit stalls and jump/branch flushes, inserting NOP bubbles (16'h0000) toward decode.

## Interface

- `WORD_W`, 16, instruction word width
- `PC_W`, 32, program counter width
- `IMM_FLAG_BIT`, 15, bit of an opcode word that marks a following immediate word

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  fetch presents a word this cycle
- `in_word`  in  WORD_W  word from instruction memory
- `in_pc`  in  PC_W  address of `in_word`
- `stall`  in  1  hazard unit: hold all state and outputs
- `flush`  in  1  taken jump/branch: discard everything held
- `fetch_hold`  out  1  tells fetch not to advance PC
- `out_valid`  out  1  decode packet valid
- `out_instr`  out  WORD_W  opcode word; 16'h0000 whenever `out_valid`=0
- `out_imm`  out  WORD_W  immediate; 0 when `out_has_imm`=0
- `out_has_imm`  out  1  packet carries an immediate
- `out_pc`  out  PC_W  address of the opcode word

## Operation

- States: `EXPECT_OP` (next word is an opcode), `WAIT_IMM` (opcode pending, next word is its immediate). Pending registers `pend_word`, `pend_pc`.
- Priority per posedge: `rst` > `flush` > `stall` > normal.
- `rst`: state `EXPECT_OP`; `out_valid`=0, `out_instr`=0, `out_imm`=0, `out_has_imm`=0, `out_pc`=0, `pend_*`=0.
- `flush`: same values as reset except `out_pc` holds; a half-assembled instruction is dropped; `in_word` that cycle is discarded.
- `stall` (no flush): state, pending and all outputs hold; `in_word` not consumed.
- `fetch_hold` = `stall & ~flush` (combinational).
- `EXPECT_OP`, `in_valid`=1:
  - `in_word[IMM_FLAG_BIT]`=0: emit packet (`out_valid`=1, `out_instr`=`in_word`, `out_pc`=`in_pc`, `out_has_imm`=0, `out_imm`=0); stay.
  - flag=1: latch `pend_word`/`pend_pc`, emit bubble, go `WAIT_IMM`.
- `EXPECT_OP`, `in_valid`=0: emit bubble.
- `WAIT_IMM`, `in_valid`=1: emit packet (`out_instr`=`pend_word`, `out_imm`=`in_word`, `out_pc`=`pend_pc`, `out_has_imm`=1); go `EXPECT_OP`. The immediate word is never flag-checked.
- `WAIT_IMM`, `in_valid`=0: emit bubble, stay.
- Bubble: `out_valid`=0, `out_instr`=0, `out_imm`=0, `out_has_imm`=0, `out_pc` holds.

## Timing

- Single-word instruction: packet valid the cycle after the posedge that accepts it (1-cycle latency).
- Two-word instruction: one bubble cycle, then the packet one cycle after the immediate word is accepted.
- `stall` held N cycles: outputs frozen N cycles, then resume with the word fetch presents at release.
- `flush` together with `stall`: flush wins, `fetch_hold`=0.
- `flush` in `WAIT_IMM`: pending opcode lost; the next accepted word is treated as an opcode.
- `rst` mid-assembly: identical to `flush`, and `out_pc` also cleared.
- Back-to-back single-word words: one packet per cycle, no bubbles.

## Configuration

- `IFID_IMM_FUSE_EN` defined: two-word fusion as above.
- Not defined: no `WAIT_IMM` state or pending registers; every valid word is emitted as a single-word packet regardless of `IMM_FLAG_BIT`; `out_has_imm` and `out_imm` are tied 0. All other behaviour is unchanged.

## Test plan

- Reset: assert `rst` 2 cycles with `in_valid`=1, `in_word`=16'h1234 -> `out_valid`=0, `out_instr`=0, `out_pc`=0 throughout; first word after release appears next cycle.
- Single-word stream: words 16'h0101, 16'h0202 at PC 0x20, 0x21 -> packets on consecutive cycles with `out_has_imm`=0 and matching `out_pc`.
- Fusion: 16'h8005 @0x30 then 16'hBEEF @0x31 -> one bubble, then `out_instr`=16'h8005, `out_imm`=16'hBEEF, `out_has_imm`=1, `out_pc`=0x30. Without `IFID_IMM_FUSE_EN`: two single-word packets instead.
- Stall: 3-cycle `stall` while holding packet 16'h0101 -> outputs unchanged, `fetch_hold`=1 for 3 cycles, next packet follows with no loss or duplication.
- Flush in `WAIT_IMM`: 16'h8005 then `flush`, then 16'h0303 @0x50 -> 16'h8005 never emitted; packet 16'h0303, `out_has_imm`=0, `out_pc`=0x50.
- `flush` and `stall` in the same cycle -> `fetch_hold`=0, `out_valid`=0 next cycle, state `EXPECT_OP`.
